pivot_cand_streamer: RTL

Feeder for the pivot-search unit. On `start` it reads one column segment from a synchronous-read column SRAM and streams each element to the pivot searcher as a valid/ready candidate tagged with its row index and an is-last flag. It then accepts the searcher's pivot result and latches it for the LU controller. It sits between the column buffer and the pivot searcher, driving both the searcher's candidate input and its result handshake.

---
 rtl/pivot_cand_streamer.sv | 217 +++++++++++++++++++++
 1 files changed

// File: rtl/pivot_cand_streamer.sv
// pivot_cand_streamer: reads a column segment from a synchronous-read SRAM
// and streams it to the pivot searcher as tagged valid/ready candidates, then
// captures the searcher's result for the LU controller.
module pivot_cand_streamer #(
  parameter int DATA_WIDTH = 32,
  parameter int ROW_IDX_W  = 16,
  parameter int ADDR_W     = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [ROW_IDX_W-1:0]  row_first,
  input  logic [ROW_IDX_W-1:0]  row_last,
  input  logic [ADDR_W-1:0]     base_addr,
  output logic                  busy,
  output logic                  mem_rd_en,
  output logic [ADDR_W-1:0]     mem_rd_addr,
  input  logic [DATA_WIDTH-1:0] mem_rd_data,
  output logic                  pivot_start,
  output logic                  cand_valid,
  input  logic                  cand_ready,
  output logic [DATA_WIDTH-1:0] cand_data,
  output logic [ROW_IDX_W-1:0]  cand_row_idx,
  output logic                  cand_is_last,
  input  logic                  pivot_valid,
  output logic                  pivot_ready,
  input  logic [DATA_WIDTH-1:0] pivot_data,
  input  logic [ROW_IDX_W-1:0]  pivot_row_idx,
  input  logic                  pivot_from_threshold,
  input  logic                  pivot_fail,
  output logic                  res_valid,
  output logic [DATA_WIDTH-1:0] res_data,
  output logic [ROW_IDX_W-1:0]  res_row_idx,
  output logic                  res_from_threshold,
  output logic                  res_fail
);

  // One extra bit so a full 2^ROW_IDX_W-row segment length is representable.
  localparam int CNT_W = ROW_IDX_W + 1;

  typedef enum logic [1:0] {
    S_IDLE     = 2'd0,
    S_STREAM   = 2'd1,
    S_WAIT_PIV = 2'd2,
    S_REPORT   = 2'd3
  } state_t;

  state_t                         state_q, state_d;
  logic [ROW_IDX_W-1:0]           row_first_q, row_first_d;
  logic [CNT_W-1:0]               n_q, n_d;
  logic [CNT_W-1:0]               rd_cnt_q, rd_cnt_d;
  logic [CNT_W-1:0]               infl_off_q, infl_off_d;
  logic [ADDR_W-1:0]              base_q, base_d;
  logic                           infl_q, infl_d;
  logic                           pivot_start_q, pivot_start_d;

  logic [1:0][DATA_WIDTH-1:0]     fifo_data_q, fifo_data_d;
  logic [1:0][ROW_IDX_W-1:0]      fifo_row_q, fifo_row_d;
  logic [1:0]                     fifo_last_q, fifo_last_d;
  logic                           wr_ptr_q, wr_ptr_d;
  logic                           rd_ptr_q, rd_ptr_d;
  logic [1:0]                     fifo_cnt_q, fifo_cnt_d;

  logic [DATA_WIDTH-1:0]          res_data_q, res_data_d;
  logic [ROW_IDX_W-1:0]           res_row_q, res_row_d;
  logic                           res_thr_q, res_thr_d;
  logic                           res_fail_q, res_fail_d;

  logic                           fifo_empty;
  logic                           pop;
  logic                           rd_en;
  logic [2:0]                     occ;
  logic [CNT_W-1:0]               n_calc;
  logic [ROW_IDX_W-1:0]           push_row;
  logic                           push_last;

  // Read-issue decision and tags for the word returning from the SRAM this cycle.
  always_comb begin
    fifo_empty = (fifo_cnt_q == 2'd0);
    pop        = ~fifo_empty & cand_ready;
    // Entries buffered plus the one in flight, after this cycle's pop: a new
    // read is only safe if that leaves room in the 2-entry FIFO.
    occ        = {1'b0, fifo_cnt_q} + {2'b00, infl_q} - {2'b00, pop};
    rd_en      = (state_q == S_STREAM) && (rd_cnt_q < n_q) && (occ < 3'd2);
    n_calc     = {1'b0, row_last} - {1'b0, row_first} + CNT_W'(1);
    push_row   = row_first_q + infl_off_q[ROW_IDX_W-1:0];
    push_last  = (infl_off_q == (n_q - CNT_W'(1)));
  end

  // Next-state logic for the FSM, read counter, FIFO and result registers.
  always_comb begin
    state_d       = state_q;
    row_first_d   = row_first_q;
    n_d           = n_q;
    base_d        = base_q;
    rd_cnt_d      = rd_cnt_q + {{(CNT_W-1){1'b0}}, rd_en};
    infl_d        = rd_en;
    infl_off_d    = rd_en ? rd_cnt_q : infl_off_q;
    pivot_start_d = 1'b0;
    fifo_data_d   = fifo_data_q;
    fifo_row_d    = fifo_row_q;
    fifo_last_d   = fifo_last_q;
    wr_ptr_d      = wr_ptr_q;
    rd_ptr_d      = rd_ptr_q;
    fifo_cnt_d    = fifo_cnt_q + {1'b0, infl_q} - {1'b0, pop};
    res_data_d    = res_data_q;
    res_row_d     = res_row_q;
    res_thr_d     = res_thr_q;
    res_fail_d    = res_fail_q;

    // SRAM data is valid exactly one cycle after its strobe.
    if (infl_q) begin
      fifo_data_d[wr_ptr_q] = mem_rd_data;
      fifo_row_d[wr_ptr_q]  = push_row;
      fifo_last_d[wr_ptr_q] = push_last;
      wr_ptr_d              = ~wr_ptr_q;
    end
    if (pop) begin
      rd_ptr_d = ~rd_ptr_q;
    end

    case (state_q)
      S_IDLE: begin
        if (start) begin
          row_first_d = row_first;
          base_d      = base_addr;
          n_d         = n_calc;
          rd_cnt_d    = '0;
          if (row_last < row_first) begin
            res_data_d = '0;
            res_row_d  = row_first;
            res_thr_d  = 1'b0;
            res_fail_d = 1'b1;
            state_d    = S_REPORT;
          end else begin
            pivot_start_d = 1'b1;
            state_d       = S_STREAM;
          end
        end
      end
      S_STREAM: begin
        if (pop && fifo_last_q[rd_ptr_q]) begin
          state_d = S_WAIT_PIV;
        end
      end
      S_WAIT_PIV: begin
        if (pivot_valid) begin
          res_data_d = pivot_data;
          res_row_d  = pivot_row_idx;
          res_thr_d  = pivot_from_threshold;
          res_fail_d = pivot_fail;
          state_d    = S_REPORT;
        end
      end
      S_REPORT: begin
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State register; FIFO payload is not reset because outputs are gated by fill count.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= S_IDLE;
      row_first_q   <= '0;
      n_q           <= '0;
      base_q        <= '0;
      rd_cnt_q      <= '0;
      infl_q        <= 1'b0;
      infl_off_q    <= '0;
      pivot_start_q <= 1'b0;
      wr_ptr_q      <= 1'b0;
      rd_ptr_q      <= 1'b0;
      fifo_cnt_q    <= 2'd0;
      res_data_q    <= '0;
      res_row_q     <= '0;
      res_thr_q     <= 1'b0;
      res_fail_q    <= 1'b0;
    end else begin
      state_q       <= state_d;
      row_first_q   <= row_first_d;
      n_q           <= n_d;
      base_q        <= base_d;
      rd_cnt_q      <= rd_cnt_d;
      infl_q        <= infl_d;
      infl_off_q    <= infl_off_d;
      pivot_start_q <= pivot_start_d;
      wr_ptr_q      <= wr_ptr_d;
      rd_ptr_q      <= rd_ptr_d;
      fifo_cnt_q    <= fifo_cnt_d;
      res_data_q    <= res_data_d;
      res_row_q     <= res_row_d;
      res_thr_q     <= res_thr_d;
      res_fail_q    <= res_fail_d;
    end
    fifo_data_q <= fifo_data_d;
    fifo_row_q  <= fifo_row_d;
    fifo_last_q <= fifo_last_d;
  end

  assign busy               = (state_q != S_IDLE);
  assign mem_rd_en          = rd_en;
  assign mem_rd_addr        = rd_en ? (base_q + ADDR_W'(rd_cnt_q)) : '0;
  assign pivot_start        = pivot_start_q;
  assign cand_valid         = ~fifo_empty;
  assign cand_data          = fifo_empty ? '0 : fifo_data_q[rd_ptr_q];
  assign cand_row_idx       = fifo_empty ? '0 : fifo_row_q[rd_ptr_q];
  assign cand_is_last       = ~fifo_empty & fifo_last_q[rd_ptr_q];
  assign pivot_ready        = (state_q == S_WAIT_PIV);
  assign res_valid          = (state_q == S_REPORT);
  assign res_data           = res_data_q;
  assign res_row_idx        = res_row_q;
  assign res_from_threshold = res_thr_q;
  assign res_fail           = res_fail_q;

endmodule
